branch_predict_unit: RTL and testbench

Dynamic branch/jump prediction and resolution unit for the 5-stage pipeline. It looks up a direct-mapped branch target buffer (BTB) with saturating direction counters at IF and predicts the next fetch PC. It resolves the prediction carried down to EX, issues a redirect/flush on mispredict, and trains the table. It replaces the static predict-not-taken detection in the PC-select path.

---
 rtl/branch_predict_unit.sv | 197 +++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Dynamic branch/jump prediction and resolution for the 5-stage pipeline.
// At IF a direct-mapped BTB with saturating direction counters predicts the
// next fetch PC. At EX the prediction carried with the instruction is
// resolved against the real outcome. On a mispredict a redirect is issued,
// which also flushes IF/ID and ID/EX. The table is trained on every valid
// EX instruction.
//
// Build option:
//   BPU_DYNAMIC_EN  defined   -> BTB plus direction counters.
//                   undefined -> no table. The unit always predicts PC+4.
//                                Resolution and statistics still work.
//
// Parameters:
//   ENTRIES  BTB entries (power of two, >= 2)
//   CNT_W    direction counter width (>= 1)
//   STAT_W   statistics counter width
//
// Ports:
//   clk             pipeline clock, rising edge
//   rstn            asynchronous active-low reset
//   if_pc           PC being fetched
//   pred_taken      IF prediction: taken
//   pred_target     IF predicted next PC (if_pc+4 when not taken)
//   ex_valid        EX instruction is valid
//   ex_npc_type     00 PC+4, 01 conditional branch, 10 jump, 11 as 00
//   ex_taken        actual branch outcome (conditional branches only)
//   ex_pc           PC of the EX instruction
//   ex_target       computed branch/jump target
//   ex_pred_taken   pred_taken piped down to EX
//   ex_pred_target  pred_target piped down to EX
//   next_type       00 keep, 01 redirect to ex_pc+4, 10 redirect to ex_target
//   redirect        next_type != 00
//   redirect_pc     redirect address, 0 when no redirect
//   stat_branches   saturating count of resolved branches and jumps
//   stat_mispred    saturating count of redirects
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [1:0]        ex_npc_type,
    input  logic              ex_taken,
    input  logic [31:0]       ex_pc,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic [1:0]        next_type,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    localparam logic [1:0] NT_KEEP     = 2'b00;
    localparam logic [1:0] NT_FALLTHRU = 2'b01;
    localparam logic [1:0] NT_TARGET   = 2'b10;

    // A correct taken prediction needs both the direction and the target.
    logic target_ok;
    assign target_ok = ex_pred_taken && (ex_pred_target == ex_target);

    // Resolution. A bubble never redirects. Type 11 falls into the default
    // arm together with plain PC+4 instructions.
    always_comb begin
        next_type = NT_KEEP;
        if (ex_valid) begin
            case (ex_npc_type)
                NPC_BRANCH: begin
                    if (ex_taken) begin
                        if (!target_ok) next_type = NT_TARGET;
                    end else if (ex_pred_taken) begin
                        next_type = NT_FALLTHRU;
                    end
                end
                NPC_JUMP: begin
                    if (!target_ok) next_type = NT_TARGET;
                end
                default: begin
                    // A non-branch that was predicted taken hit an aliased entry.
                    if (ex_pred_taken) next_type = NT_FALLTHRU;
                end
            endcase
        end
    end

    assign redirect = (next_type != NT_KEEP);

    always_comb begin
        redirect_pc = 32'h0;
        if (next_type == NT_TARGET)        redirect_pc = ex_target;
        else if (next_type == NT_FALLTHRU) redirect_pc = ex_pc + 32'd4;
    end

    logic is_cf;
    assign is_cf = ex_valid && (ex_npc_type == NPC_BRANCH || ex_npc_type == NPC_JUMP);

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (is_cf && (stat_branches != '1)) stat_branches <= stat_branches + 1'b1;
            if (redirect && (stat_mispred != '1)) stat_mispred <= stat_mispred + 1'b1;
        end
    end

`ifdef BPU_DYNAMIC_EN
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Reset value is weakly not-taken. A new entry starts at weakly taken.
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // The lookup reads registered state only. A same-cycle update to the
    // same index is therefore not seen until the following cycle.
    assign pred_taken  = if_hit && cnt_q[if_idx][CNT_W-1];
    assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             do_alloc;
    logic             do_dec;
    logic             do_inval;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign do_alloc = (ex_npc_type == NPC_JUMP) || ((ex_npc_type == NPC_BRANCH) && ex_taken);
    assign do_dec   = (ex_npc_type == NPC_BRANCH) && !ex_taken && ex_hit;
    assign do_inval = ((ex_npc_type == NPC_SEQ) || (ex_npc_type == 2'b11)) && ex_hit;

    // Training. A hit keeps counting up. A miss replaces whatever occupied
    // the slot and restarts the counter at weakly taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else if (ex_valid) begin
            if (do_alloc) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                if (!ex_hit)                      cnt_q[ex_idx] <= CNT_ALLOC;
                else if (cnt_q[ex_idx] != CNT_MAX) cnt_q[ex_idx] <= cnt_q[ex_idx] + 1'b1;
            end else if (do_dec) begin
                if (cnt_q[ex_idx] != '0) cnt_q[ex_idx] <= cnt_q[ex_idx] - 1'b1;
            end else if (do_inval) begin
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end
`else
    // Static fallback: predict sequential flow on every fetch.
    assign pred_taken  = 1'b0;
    assign pred_target = if_pc + 32'd4;

    logic unused_cfg;
    assign unused_cfg = ^{ENTRIES[0], CNT_W[0]};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Self-checking bench for branch_predict_unit. A behavioural model keeps the
// BTB as plain integer arrays and the statistics as integers. Directed
// scenarios run first. Randomized traffic over an aliasing PC range follows.
// The bench follows BPU_DYNAMIC_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 2;
    localparam int STAT_W  = 32;

`ifdef BPU_DYNAMIC_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif

    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int CNT_HALF = 1 << (CNT_W - 1);

    logic              clk;
    logic              rstn;
    logic [31:0]       if_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              ex_valid;
    logic [1:0]        ex_npc_type;
    logic              ex_taken;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_target;
    logic              ex_pred_taken;
    logic [31:0]       ex_pred_target;
    logic [1:0]        next_type;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    int assertCount = 0;
    int failCount   = 0;

    branch_predict_unit #(
        .ENTRIES(ENTRIES),
        .CNT_W  (CNT_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_valid      (ex_valid),
        .ex_npc_type   (ex_npc_type),
        .ex_taken      (ex_taken),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .next_type     (next_type),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit          mValid  [ENTRIES];
    int unsigned mTag    [ENTRIES];
    logic [31:0] mTarget [ENTRIES];
    int          mCnt    [ENTRIES];
    longint      mBranches;
    longint      mMispred;

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return int'(pc / (4 * ENTRIES));
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = 0;
            mTarget[i] = 32'h0;
            mCnt[i]    = CNT_HALF - 1;
        end
        mBranches = 0;
        mMispred  = 0;
    endfunction

    function automatic bit modelHit(input logic [31:0] pc);
        int i;
        i = idxOf(pc);
        return DYN && mValid[i] && (mTag[i] == tagOf(pc));
    endfunction

    // Predict taken when the counter is in its upper half.
    function automatic void modelPredict(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
        tk  = modelHit(pc) && (mCnt[idxOf(pc)] >= CNT_HALF);
        tgt = tk ? mTarget[idxOf(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [1:0] modelNextType();
        bit predOk;
        predOk = ex_pred_taken && (ex_pred_target == ex_target);
        if (!ex_valid) return 2'd0;
        if (ex_npc_type == 2'd1) begin
            if (ex_taken) return predOk ? 2'd0 : 2'd2;
            return ex_pred_taken ? 2'd1 : 2'd0;
        end
        if (ex_npc_type == 2'd2) return predOk ? 2'd0 : 2'd2;
        return ex_pred_taken ? 2'd1 : 2'd0;
    endfunction

    function automatic void modelTrain();
        int  i;
        bit  hit;
        if (!ex_valid) return;
        if (ex_npc_type == 2'd1 || ex_npc_type == 2'd2) mBranches++;
        if (modelNextType() != 2'd0) mMispred++;
        if (!DYN) return;
        i   = idxOf(ex_pc);
        hit = modelHit(ex_pc);
        if (ex_npc_type == 2'd2 || (ex_npc_type == 2'd1 && ex_taken)) begin
            mCnt[i]    = hit ? ((mCnt[i] < CNT_MAX) ? mCnt[i] + 1 : CNT_MAX) : CNT_HALF;
            mValid[i]  = 1'b1;
            mTag[i]    = tagOf(ex_pc);
            mTarget[i] = ex_target;
        end else if (ex_npc_type == 2'd1) begin
            if (hit && mCnt[i] > 0) mCnt[i]--;
        end else if (hit) begin
            mValid[i] = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] ty, input logic tk,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic ptk, input logic [31:0] ptgt,
                                 input logic [31:0] fetchPc);
        @(negedge clk);
        ex_valid       = v;
        ex_npc_type    = ty;
        ex_taken       = tk;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        if_pc          = fetchPc;
    endtask

    // Compare every output with the model before the edge, then train the
    // model at the edge alongside the DUT.
    task automatic checkCycle();
        bit          eTk;
        logic [31:0] eTgt;
        logic [1:0]  eNt;
        logic [31:0] eRpc;
        #1;
        modelPredict(if_pc, eTk, eTgt);
        eNt  = modelNextType();
        eRpc = (eNt == 2'd2) ? ex_target : (eNt == 2'd1) ? ex_pc + 32'd4 : 32'h0;
        checkOutput("pred_taken",    32'(pred_taken), 32'(eTk));
        checkOutput("pred_target",   pred_target, eTgt);
        checkOutput("next_type",     32'(next_type), 32'(eNt));
        checkOutput("redirect",      32'(redirect), 32'(eNt != 2'd0));
        checkOutput("redirect_pc",   redirect_pc, eRpc);
        checkOutput("stat_branches", stat_branches, 32'(mBranches));
        checkOutput("stat_mispred",  stat_mispred, 32'(mMispred));
        @(posedge clk);
        if (rstn) modelTrain();
    endtask

    function automatic logic [31:0] randPc();
        return 32'h100 + 32'(4 * $urandom_range(0, 47));
    endfunction

    initial begin
        bit          pTk;
        logic [31:0] pTgt;

        rstn = 1'b0;
        ex_valid = 1'b0; ex_npc_type = 2'd0; ex_taken = 1'b0;
        ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        if_pc = 32'h40;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_pred_taken",  32'(pred_taken), 32'h0);
        checkOutput("reset_pred_target", pred_target, 32'h44);
        checkOutput("reset_stat_br",     stat_branches, 32'h0);
        checkOutput("reset_stat_mis",    stat_mispred, 32'h0);
        rstn = 1'b1;

        // Taken branch at 0x100 to 0x80, not predicted.
        applyStimulus(1, 2'd1, 1, 32'h100, 32'h80, 0, 32'h104, 32'h40);
        #1;
        checkOutput("br_taken_next_type", 32'(next_type), 32'd2);
        checkOutput("br_taken_redirect_pc", redirect_pc, 32'h80);
        checkCycle();
        applyStimulus(0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h100);
        #1;
        checkOutput("lookup_after_train", 32'(pred_taken), 32'(DYN));
        checkCycle();

        // Taken three times, then not-taken while predicted taken.
        repeat (3) begin
            modelPredict(32'h100, pTk, pTgt);
            applyStimulus(1, 2'd1, 1, 32'h100, 32'h80, pTk, pTgt, 32'h100);
            checkCycle();
        end
        applyStimulus(1, 2'd1, 0, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        #1;
        checkOutput("br_nt_next_type", 32'(next_type), 32'd1);
        checkOutput("br_nt_redirect_pc", redirect_pc, 32'h104);
        checkCycle();
        applyStimulus(0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h100);
        checkCycle();

        // Jump at 0x200 to 0x300, trained then predicted correctly.
        applyStimulus(1, 2'd2, 0, 32'h200, 32'h300, 0, 32'h204, 32'h200);
        checkCycle();
        modelPredict(32'h200, pTk, pTgt);
        applyStimulus(1, 2'd2, 0, 32'h200, 32'h300, pTk, pTgt, 32'h200);
        checkCycle();

        // Aliased PC+4 instruction at 0x140 predicted taken.
        applyStimulus(1, 2'd0, 0, 32'h140, 32'h0, 1, 32'h80, 32'h100);
        #1;
        checkOutput("alias_next_type", 32'(next_type), 32'd1);
        checkOutput("alias_redirect_pc", redirect_pc, 32'h144);
        checkCycle();
        applyStimulus(0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h100);
        checkCycle();

        // Bubble with every other EX input asserted.
        applyStimulus(0, 2'd2, 1, 32'h100, 32'h999C, 0, 32'h0, 32'h200);
        #1;
        checkOutput("bubble_redirect", 32'(redirect), 32'h0);
        checkCycle();
        applyStimulus(0, 2'd1, 1, 32'h200, 32'h500, 1, 32'h0, 32'h200);
        checkCycle();

        // Randomized traffic with a mid-run reset.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            pc = randPc();
            modelPredict(pc, pTk, pTgt);
            if ($urandom_range(0, 3) == 0) begin
                pTk  = 1'($urandom_range(0, 1));
                pTgt = 32'h80 + 32'(4 * $urandom_range(0, 3));
            end
            applyStimulus(1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), pc, 32'h80 + 32'(4 * $urandom_range(0, 3)),
                          pTk, pTgt, randPc());
            checkCycle();
            if (n == 300) begin
                @(negedge clk);
                #2;
                rstn = 1'b0;
                modelReset();
                ex_valid = 1'b0;
                if_pc    = 32'h100;
                #1;
                checkOutput("midreset_pred_taken", 32'(pred_taken), 32'h0);
                checkOutput("midreset_stat_br", stat_branches, 32'h0);
                checkCycle();
                @(negedge clk);
                rstn = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
